msh_mem_req_arb: RTL and testbench
==================================

MSH_MEM_REQ_ARB -- requirements
Module: msh_mem_req_arb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, memory word address width.
REQ-002 The block SHALL have parameter DATA_W, default 64, write data width.
REQ-003 The block SHALL have parameter TAG_W, default 4, read tag width.
REQ-004 The block SHALL have parameter DEPTH, default 4, entries per request FIFO (power of 2, >=2).
REQ-005 The block SHALL have parameter STARVE_MAX, default 8, maximum consecutive read issues while writes wait.
REQ-006 The block SHALL have port mclk, input, 1, mesh clock; the only clock.
REQ-007 The block SHALL have port mrst_n, input, 1, reset; asynchronous, active-low.
REQ-008 The block SHALL have ports i_wr_vld (input, 1), o_wr_rdy (output, 1), i_wr_addr (input, ADDR_W) and i_wr_data (input, DATA_W), the write request channel.
REQ-009 The block SHALL have ports i_rd_vld (input, 1), o_rd_rdy (output, 1), i_rd_addr (input, ADDR_W) and i_rd_tag (input, TAG_W), the read request channel.
REQ-010 The block SHALL have port i_mem_stall, input, 1, memory cannot accept a command this cycle.
REQ-011 The block SHALL have ports o_mem_en (1), o_mem_wen (1), o_mem_addr (ADDR_W), o_mem_wdata (DATA_W) and o_mem_tag (TAG_W), all outputs, the registered command to msh_mem.
REQ-012 The block SHALL have ports o_wr_cnt and o_rd_cnt, outputs, clog2(DEPTH)+1 bits each, FIFO occupancy.

Function
REQ-013 The block SHALL hold writes and reads in separate FIFOs of DEPTH entries; a transfer occurs when vld&&rdy at the mclk rising edge.
REQ-014 The block SHALL drive o_wr_rdy = (o_wr_cnt < DEPTH) and o_rd_rdy = (o_rd_cnt < DEPTH) from registered counts only; a pop in the same cycle does not open a slot to a push.
REQ-015 The block SHALL have no combinational path from any input to o_wr_rdy or o_rd_rdy.
REQ-016 The block SHALL issue a request accepted at edge N as o_mem_en=1 in the cycle after edge N+1 at the earliest (2-cycle minimum latency).
REQ-017 The block SHALL pop nothing and register o_mem_en=0 at the next edge in a cycle with i_mem_stall=1.
REQ-018 Arbitration, with i_mem_stall=0 and both FIFOs empty: the block SHALL issue nothing and register o_mem_en=0.
REQ-019 Arbitration, with only one FIFO non-empty: the block SHALL pop that FIFO's head.
REQ-020 Arbitration, with both FIFOs non-empty: the block SHALL give reads priority unless any of the following holds: (a) the write FIFO is full; (b) the starve counter equals STARVE_MAX; (c) the read head address equals the address of any valid write-FIFO entry (RAW hazard). In those cases the write head SHALL be popped.
REQ-021 The block SHALL, under a RAW hazard, keep the read head blocked until no matching write remains, so reads always observe earlier-accepted writes to the same address.
REQ-022 The block SHALL keep a starve counter of width clog2(STARVE_MAX+1).
REQ-023 The block SHALL increment the starve counter on each read issue while the write FIFO is non-empty, saturating at STARVE_MAX.
REQ-024 The block SHALL clear the starve counter on any write issue or whenever the write FIFO is empty.
REQ-025 On issue, the block SHALL register the following:
- o_mem_en=1;
- o_mem_wen=1 for a write, 0 for a read;
- o_mem_addr from the FIFO head;
- o_mem_wdata from the write head for a write, held at its previous value for a read;
- o_mem_tag from the read head for a read, held for a write.
REQ-026 The block SHALL wrap FIFO pointers modulo DEPTH.
REQ-027 The block SHALL update counts as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-028 The block SHALL preserve ordering within each FIFO; cross-channel ordering is defined only by REQ-020 and REQ-021.

Reset
REQ-029 The block SHALL, while mrst_n=0, asynchronously force the following:
- o_mem_en=0, o_mem_wen=0;
- o_mem_addr, o_mem_wdata and o_mem_tag to 0;
- both counts to 0, pointers to 0, starve counter to 0;
- o_wr_rdy=1 and o_rd_rdy=1.
REQ-030 The block SHALL discard all buffered requests and any in-flight command on reset mid-operation, with no o_mem_en pulse during or after reset until new requests are accepted.
REQ-031 The block SHALL register rdy and command outputs one cycle after mrst_n deasserts; the first push is legal in the first cycle after deassertion.

Verification
REQ-032 The bench SHALL cover single read: read addr 0x010, tag 3, accepted at edge 0 -> o_mem_en=1, o_mem_wen=0, o_mem_addr=0x010, o_mem_tag=3 in the cycle after edge 1.
REQ-033 The bench SHALL cover RAW hazard: write 0x020/data 0xAA accepted and stall held until a read of 0x020 is also queued, then stall released -> write issued before read.
REQ-034 The bench SHALL cover starvation: 1 write pending plus continuous reads to distinct addresses -> exactly 8 reads issue, then the write, then reads resume.
REQ-035 The bench SHALL cover full/backpressure: i_mem_stall=1, push 5 writes -> o_wr_rdy=0 after 4 accepted, o_wr_cnt=4; stall released -> o_wr_rdy=1 one cycle after the first pop.
REQ-036 The bench SHALL cover wrap-around: 10 writes and 10 reads interleaved under random stall -> all issued in per-channel order with correct data and tags.
REQ-037 The bench SHALL cover reset mid-operation: mrst_n=0 with 3 writes and 2 reads queued -> outputs zero immediately, counts 0, no command issued after release.

Source files
------------

// File: rtl/msh_mem_req_arb.sv
// Write/read request arbiter in front of msh_mem: two request FIFOs feed one registered
// memory command. Reads win by default; writes win when full, starved, or hiding a RAW hazard.
module msh_mem_req_arb #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 4,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                   mclk,
    input  logic                   mrst_n,
    input  logic                   i_wr_vld,
    output logic                   o_wr_rdy,
    input  logic [ADDR_W-1:0]      i_wr_addr,
    input  logic [DATA_W-1:0]      i_wr_data,
    input  logic                   i_rd_vld,
    output logic                   o_rd_rdy,
    input  logic [ADDR_W-1:0]      i_rd_addr,
    input  logic [TAG_W-1:0]       i_rd_tag,
    input  logic                   i_mem_stall,
    output logic                   o_mem_en,
    output logic                   o_mem_wen,
    output logic [ADDR_W-1:0]      o_mem_addr,
    output logic [DATA_W-1:0]      o_mem_wdata,
    output logic [TAG_W-1:0]       o_mem_tag,
    output logic [$clog2(DEPTH):0] o_wr_cnt,
    output logic [$clog2(DEPTH):0] o_rd_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [ADDR_W-1:0] wr_addr_mem [DEPTH];
    logic [DATA_W-1:0] wr_data_mem [DEPTH];
    logic [ADDR_W-1:0] rd_addr_mem [DEPTH];
    logic [TAG_W-1:0]  rd_tag_mem  [DEPTH];

    logic [PW-1:0] wr_wptr, wr_rptr, rd_wptr, rd_rptr;
    logic [CW-1:0] wr_cnt, rd_cnt;
    logic [SW-1:0] starve_cnt;

    logic wr_push, rd_push;
    logic wr_ne, rd_ne, wr_full, starve_hit, raw_hit;
    logic pick_wr, issue_wr, issue_rd;

    // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
    assign o_wr_rdy = (wr_cnt < CW'(DEPTH));
    assign o_rd_rdy = (rd_cnt < CW'(DEPTH));
    assign o_wr_cnt = wr_cnt;
    assign o_rd_cnt = rd_cnt;

    assign wr_push = i_wr_vld && o_wr_rdy;
    assign rd_push = i_rd_vld && o_rd_rdy;

    always_ff @(posedge mclk) begin
        if (wr_push) begin
            wr_addr_mem[wr_wptr] <= i_wr_addr;
            wr_data_mem[wr_wptr] <= i_wr_data;
        end
        if (rd_push) begin
            rd_addr_mem[rd_wptr] <= i_rd_addr;
            rd_tag_mem[rd_wptr]  <= i_rd_tag;
        end
    end

    // Compare the read head against every occupied write slot, oldest first.
    always_comb begin
        raw_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < wr_cnt) &&
                (wr_addr_mem[wr_rptr + PW'(k)] == rd_addr_mem[rd_rptr]))
                raw_hit = 1'b1;
        end
    end

    always_comb begin
        wr_ne      = (wr_cnt != '0);
        rd_ne      = (rd_cnt != '0);
        wr_full    = (wr_cnt == CW'(DEPTH));
        starve_hit = (starve_cnt == SW'(STARVE_MAX));
        pick_wr    = wr_ne && (!rd_ne || wr_full || starve_hit || raw_hit);
        issue_wr   = !i_mem_stall && pick_wr;
        issue_rd   = !i_mem_stall && rd_ne && !pick_wr;
    end

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            wr_wptr <= '0;
            wr_rptr <= '0;
            rd_wptr <= '0;
            rd_rptr <= '0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            if (wr_push)  wr_wptr <= wr_wptr + PW'(1);
            if (issue_wr) wr_rptr <= wr_rptr + PW'(1);
            if (rd_push)  rd_wptr <= rd_wptr + PW'(1);
            if (issue_rd) rd_rptr <= rd_rptr + PW'(1);
            case ({wr_push, issue_wr})
                2'b10:   wr_cnt <= wr_cnt + CW'(1);
                2'b01:   wr_cnt <= wr_cnt - CW'(1);
                default: wr_cnt <= wr_cnt;
            endcase
            case ({rd_push, issue_rd})
                2'b10:   rd_cnt <= rd_cnt + CW'(1);
                2'b01:   rd_cnt <= rd_cnt - CW'(1);
                default: rd_cnt <= rd_cnt;
            endcase
        end
    end

    // Counts reads that overtook a waiting write; cleared once writes drain or one issues.
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            starve_cnt <= '0;
        end else if (!wr_ne || issue_wr) begin
            starve_cnt <= '0;
        end else if (issue_rd && !starve_hit) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            o_mem_en    <= 1'b0;
            o_mem_wen   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_tag   <= '0;
        end else begin
            o_mem_en <= issue_wr || issue_rd;
            if (issue_wr) begin
                o_mem_wen   <= 1'b1;
                o_mem_addr  <= wr_addr_mem[wr_rptr];
                o_mem_wdata <= wr_data_mem[wr_rptr];
            end else if (issue_rd) begin
                o_mem_wen  <= 1'b0;
                o_mem_addr <= rd_addr_mem[rd_rptr];
                o_mem_tag  <= rd_tag_mem[rd_rptr];
            end
        end
    end

endmodule

// File: tb/tb_msh_mem_req_arb.sv
// Scoreboard bench for msh_mem_req_arb: accepted requests are queued per channel and
// matched against every command the arbiter issues.
module tb_msh_mem_req_arb;

    typedef struct packed {
        logic [11:0] addr;
        logic [63:0] data;
    } wr_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [3:0]  tag;
    } rd_t;

    logic        mclk;
    logic        mrst_n;
    logic        i_wr_vld, o_wr_rdy;
    logic [11:0] i_wr_addr;
    logic [63:0] i_wr_data;
    logic        i_rd_vld, o_rd_rdy;
    logic [11:0] i_rd_addr;
    logic [3:0]  i_rd_tag;
    logic        i_mem_stall;
    logic        o_mem_en, o_mem_wen;
    logic [11:0] o_mem_addr;
    logic [63:0] o_mem_wdata;
    logic [3:0]  o_mem_tag;
    logic [2:0]  o_wr_cnt, o_rd_cnt;

    int   total;
    int   bad;
    wr_t  wr_exp [$];
    rd_t  rd_exp [$];
    logic issue_log [$];
    logic [63:0] model_wdata;
    logic [3:0]  model_tag;
    logic        stall_q;
    wr_t  mon_w;
    rd_t  mon_r;

    msh_mem_req_arb dut (
        .mclk        (mclk),
        .mrst_n      (mrst_n),
        .i_wr_vld    (i_wr_vld),
        .o_wr_rdy    (o_wr_rdy),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data),
        .i_rd_vld    (i_rd_vld),
        .o_rd_rdy    (o_rd_rdy),
        .i_rd_addr   (i_rd_addr),
        .i_rd_tag    (i_rd_tag),
        .i_mem_stall (i_mem_stall),
        .o_mem_en    (o_mem_en),
        .o_mem_wen   (o_mem_wen),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_tag   (o_mem_tag),
        .o_wr_cnt    (o_wr_cnt),
        .o_rd_cnt    (o_rd_cnt)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: drive one cycle, log accepted requests, return at the next negedge.
    task automatic applyStimulus(input logic wv, input logic [11:0] wa, input logic [63:0] wd,
                                 input logic rv, input logic [11:0] ra, input logic [3:0] rt,
                                 input logic st, output logic wacc, output logic racc);
        i_wr_vld    = wv;
        i_wr_addr   = wa;
        i_wr_data   = wd;
        i_rd_vld    = rv;
        i_rd_addr   = ra;
        i_rd_tag    = rt;
        i_mem_stall = st;
        wacc = wv && o_wr_rdy;
        racc = rv && o_rd_rdy;
        if (wacc) wr_exp.push_back('{addr: wa, data: wd});
        if (racc) rd_exp.push_back('{addr: ra, tag: rt});
        @(negedge mclk);
    endtask

    task automatic idleCycle(input logic st);
        logic wa, ra;
        applyStimulus(1'b0, 12'h0, 64'h0, 1'b0, 12'h0, 4'h0, st, wa, ra);
    endtask

    task automatic drainQueues(input int maxc, input string tag);
        int i = 0;
        while (i < maxc && (wr_exp.size() != 0 || rd_exp.size() != 0)) begin
            idleCycle(1'b0);
            i++;
        end
        checkOutput(tag, 64'(wr_exp.size() + rd_exp.size()), 64'h0);
        idleCycle(1'b0);
    endtask

    always @(posedge mclk) stall_q <= i_mem_stall;

    // Monitor: every issued command must match the head of its channel's expectation queue.
    always @(negedge mclk) begin
        if (stall_q === 1'b1) checkOutput("stall_idle", 64'(o_mem_en), 64'h0);
        if (o_mem_en === 1'b1) begin
            issue_log.push_back(o_mem_wen);
            if (o_mem_wen) begin
                checkOutput("wr_expected", 64'(wr_exp.size() != 0), 64'h1);
                if (wr_exp.size() != 0) begin
                    mon_w = wr_exp.pop_front();
                    checkOutput("wr_addr", 64'(o_mem_addr), 64'(mon_w.addr));
                    checkOutput("wr_data", o_mem_wdata, mon_w.data);
                    checkOutput("wr_tag_hold", 64'(o_mem_tag), 64'(model_tag));
                    model_wdata = mon_w.data;
                end
            end else begin
                checkOutput("rd_expected", 64'(rd_exp.size() != 0), 64'h1);
                if (rd_exp.size() != 0) begin
                    mon_r = rd_exp.pop_front();
                    checkOutput("rd_addr", 64'(o_mem_addr), 64'(mon_r.addr));
                    checkOutput("rd_tag", 64'(o_mem_tag), 64'(mon_r.tag));
                    checkOutput("rd_wdata_hold", o_mem_wdata, model_wdata);
                    model_tag = mon_r.tag;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic wa, ra;
        int   n, ws, rs, acc;
        logic [63:0] d;

        total = 0;
        bad = 0;
        model_wdata = 64'h0;
        model_tag = 4'h0;
        mrst_n = 1'b1;
        i_wr_vld = 1'b0;
        i_wr_addr = 12'h0;
        i_wr_data = 64'h0;
        i_rd_vld = 1'b0;
        i_rd_addr = 12'h0;
        i_rd_tag = 4'h0;
        i_mem_stall = 1'b0;

        // reset state
        #2 mrst_n = 1'b0;
        #1;
        checkOutput("rst_en", 64'(o_mem_en), 64'h0);
        checkOutput("rst_wen", 64'(o_mem_wen), 64'h0);
        checkOutput("rst_addr", 64'(o_mem_addr), 64'h0);
        checkOutput("rst_wdata", o_mem_wdata, 64'h0);
        checkOutput("rst_tag", 64'(o_mem_tag), 64'h0);
        checkOutput("rst_wr_cnt", 64'(o_wr_cnt), 64'h0);
        checkOutput("rst_rd_cnt", 64'(o_rd_cnt), 64'h0);
        checkOutput("rst_wr_rdy", 64'(o_wr_rdy), 64'h1);
        checkOutput("rst_rd_rdy", 64'(o_rd_rdy), 64'h1);
        @(negedge mclk);
        @(negedge mclk);
        mrst_n = 1'b1;

        // single read: accepted at edge 0, command visible after edge 1
        applyStimulus(1'b0, 12'h0, 64'h0, 1'b1, 12'h010, 4'd3, 1'b0, wa, ra);
        checkOutput("single_acc", 64'(ra), 64'h1);
        checkOutput("single_lat0_en", 64'(o_mem_en), 64'h0);
        checkOutput("single_rd_cnt", 64'(o_rd_cnt), 64'h1);
        idleCycle(1'b0);
        checkOutput("single_en", 64'(o_mem_en), 64'h1);
        checkOutput("single_wen", 64'(o_mem_wen), 64'h0);
        checkOutput("single_addr", 64'(o_mem_addr), 64'h010);
        checkOutput("single_tag", 64'(o_mem_tag), 64'h3);
        drainQueues(20, "single_drain");

        // RAW: head read 0x040 goes first, then the write must precede the read of 0x020
        issue_log.delete();
        applyStimulus(1'b1, 12'h020, 64'hAA, 1'b0, 12'h0, 4'h0, 1'b1, wa, ra);
        applyStimulus(1'b0, 12'h0, 64'h0, 1'b1, 12'h040, 4'd1, 1'b1, wa, ra);
        applyStimulus(1'b0, 12'h0, 64'h0, 1'b1, 12'h020, 4'd2, 1'b1, wa, ra);
        drainQueues(20, "raw_drain");
        checkOutput("raw_len", 64'(issue_log.size()), 64'h3);
        for (int i = 0; i < 3; i++)
            if (i < issue_log.size())
                checkOutput($sformatf("raw_seq%0d", i), 64'(issue_log[i]), 64'(i == 1));

        // starvation: one write against a continuous read stream
        issue_log.delete();
        n = 0;
        applyStimulus(1'b1, 12'h100, 64'h5555, 1'b0, 12'h0, 4'h0, 1'b1, wa, ra);
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b0, 12'h0, 64'h0, 1'b1, 12'h200 + 12'(n), 4'(n), 1'b1, wa, ra);
            if (ra) n++;
        end
        for (int c = 0; c < 16; c++) begin
            applyStimulus(1'b0, 12'h0, 64'h0, 1'b1, 12'h200 + 12'(n), 4'(n), 1'b0, wa, ra);
            if (ra) n++;
        end
        drainQueues(40, "starve_drain");
        checkOutput("starve_len_ok", 64'(issue_log.size() >= 10), 64'h1);
        for (int i = 0; i < 10; i++)
            if (i < issue_log.size())
                checkOutput($sformatf("starve_seq%0d", i), 64'(issue_log[i]), 64'(i == 8));

        // full / backpressure
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 12'h700 + 12'(i), 64'h1000 + 64'(i), 1'b0, 12'h0, 4'h0, 1'b1, wa, ra);
            if (wa) acc++;
        end
        checkOutput("full_acc", 64'(acc), 64'h4);
        checkOutput("full_rdy", 64'(o_wr_rdy), 64'h0);
        checkOutput("full_cnt", 64'(o_wr_cnt), 64'h4);
        idleCycle(1'b0);
        checkOutput("full_rdy_after_pop", 64'(o_wr_rdy), 64'h1);
        checkOutput("full_cnt_after_pop", 64'(o_wr_cnt), 64'h3);
        drainQueues(20, "full_drain");

        // wrap-around under random stall
        ws = 0;
        rs = 0;
        for (int c = 0; c < 300 && (ws < 10 || rs < 10); c++) begin
            d = {$urandom(), $urandom()};
            applyStimulus((ws < 10) && ($urandom_range(0, 1) == 1), 12'h300 + 12'(ws), d,
                          (rs < 10) && ($urandom_range(0, 1) == 1), 12'h400 + 12'(rs), 4'(rs),
                          $urandom_range(0, 3) == 0, wa, ra);
            if (wa) ws++;
            if (ra) rs++;
        end
        checkOutput("wrap_wr_sent", 64'(ws), 64'd10);
        checkOutput("wrap_rd_sent", 64'(rs), 64'd10);
        drainQueues(60, "wrap_drain");

        // reset mid-operation with a command in flight
        applyStimulus(1'b1, 12'h500, 64'h11, 1'b1, 12'h600, 4'd6, 1'b1, wa, ra);
        applyStimulus(1'b1, 12'h501, 64'h22, 1'b1, 12'h601, 4'd7, 1'b1, wa, ra);
        applyStimulus(1'b1, 12'h502, 64'h33, 1'b1, 12'h602, 4'd8, 1'b1, wa, ra);
        idleCycle(1'b0);
        checkOutput("prerst_en", 64'(o_mem_en), 64'h1);
        checkOutput("prerst_wr_cnt", 64'(o_wr_cnt), 64'h3);
        checkOutput("prerst_rd_cnt", 64'(o_rd_cnt), 64'h2);
        #2 mrst_n = 1'b0;
        #1;
        wr_exp.delete();
        rd_exp.delete();
        issue_log.delete();
        model_wdata = 64'h0;
        model_tag = 4'h0;
        checkOutput("midrst_en", 64'(o_mem_en), 64'h0);
        checkOutput("midrst_wen", 64'(o_mem_wen), 64'h0);
        checkOutput("midrst_addr", 64'(o_mem_addr), 64'h0);
        checkOutput("midrst_wdata", o_mem_wdata, 64'h0);
        checkOutput("midrst_tag", 64'(o_mem_tag), 64'h0);
        checkOutput("midrst_wr_cnt", 64'(o_wr_cnt), 64'h0);
        checkOutput("midrst_rd_cnt", 64'(o_rd_cnt), 64'h0);
        checkOutput("midrst_wr_rdy", 64'(o_wr_rdy), 64'h1);
        checkOutput("midrst_rd_rdy", 64'(o_rd_rdy), 64'h1);
        @(negedge mclk);
        @(negedge mclk);
        mrst_n = 1'b1;
        for (int c = 0; c < 10; c++) idleCycle(1'b0);
        checkOutput("postrst_noissue", 64'(issue_log.size()), 64'h0);
        checkOutput("postrst_wr_cnt", 64'(o_wr_cnt), 64'h0);
        checkOutput("postrst_rd_cnt", 64'(o_rd_cnt), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
